// File: rtl/dec_ser_pkg.sv
// dec_ser_pkg
//   Shared types and constants for the decimation-channel serializer scheduler.
//   sched_state_t : scheduler FSM state encoding
//   GAP_CYC       : strobe-low cycles forced after every transfer
//   DATA_W_DEF    : default channel word width
package dec_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int GAP_CYC    = 4;
  localparam int DATA_W_DEF = 22;

endpackage

// File: rtl/dec_rr_picker.sv
// dec_rr_picker
//   Round-robin first-set search: returns the first asserted request at or
//   after ptr, wrapping past N_CH-1 back to 0.
//   Ports:
//     req     [N_CH-1:0]  request vector
//     ptr     [IDX_W-1:0] search start index
//     grant   [IDX_W-1:0] index of the first set request (0 when none)
//     req_any             at least one request is set
module dec_rr_picker
  import dec_ser_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [$clog2(N_CH)-1:0] grant,
  output logic                    req_any
);

  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W:0] pos;
  logic           found;

  // pos carries one extra bit so ptr + k can be wrapped for any N_CH,
  // not only powers of two.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_CH; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_CH)) begin
        pos = pos - (IDX_W + 1)'(N_CH);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = pos[IDX_W-1:0];
      end
    end
  end

  assign req_any = |req;

endmodule

// File: rtl/dec_ser_scheduler.sv
// dec_ser_scheduler
//   Shares one serializer among N_CH decimation channels. Each channel word is
//   latched in a hold register, granted round-robin, and handed over with a
//   level strobe / busy handshake. A fixed strobe-low gap follows every
//   transfer so a 3-stage synchronizer on the far side always sees an edge.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     ch_valid      per-channel one-cycle word-ready pulse
//     ch_data       channel i word in [i*DATA_W +: DATA_W]
//     ser_busy      serializer busy flag
//     ser_strobe    level strobe to serializer
//     ser_data      word presented to serializer (stable grant to grant)
//     ser_ch        channel index of ser_data
//     overrun       sticky per-channel "word overwritten before grant"
//     err_timeout   sticky "serializer never went busy"
//     clr_err       synchronous clear of overrun/err_timeout (a same-cycle set wins)
//   Build option DEC_SER_SCHED_OVR_CNT_EN adds ovr_cnt [N_CH*8]: one 8-bit
//   saturating overrun counter per channel, cleared by clr_err and rst.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | no transfer; grants first pending channel from rr_ptr
//   WAIT_BUSY | strobe high, waiting for ser_busy (bounded by TIMEOUT)
//   WAIT_DONE | serializer busy, waiting for it to finish
//   GAP       | strobe held low for GAP_CYC cycles before next grant
module dec_ser_scheduler
  import dec_ser_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic                     ser_busy,
  output logic                     ser_strobe,
  output logic [DATA_W-1:0]        ser_data,
  output logic [$clog2(N_CH)-1:0]  ser_ch,
  output logic [N_CH-1:0]          overrun,
  output logic                     err_timeout,
  input  logic                     clr_err
`ifdef DEC_SER_SCHED_OVR_CNT_EN
  ,
  output logic [N_CH*8-1:0]        ovr_cnt
`endif
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_t      state;
  logic [DATA_W-1:0] hold [N_CH];
  logic [N_CH-1:0]   pend;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gidx;
  logic              req_any;
  logic              grant_now;
  logic [N_CH-1:0]   grant_vec;
  logic [N_CH-1:0]   ovr_evt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  dec_rr_picker #(.N_CH(N_CH)) u_picker (
    .req     (pend),
    .ptr     (rr_ptr),
    .grant   (gidx),
    .req_any (req_any)
  );

  assign grant_now = (state == IDLE) && req_any;

  always_comb begin
    grant_vec = '0;
    if (grant_now) begin
      grant_vec[gidx] = 1'b1;
    end
  end

  // A new word landing in the very cycle its channel is granted is not an
  // overrun: the granted word is read out of hold on this edge.
  assign ovr_evt = ch_valid & pend & ~grant_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_valid[i]) begin
          hold[i] <= ch_data[i*DATA_W +: DATA_W];
          pend[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
      overrun <= (clr_err ? '0 : overrun) | ovr_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ser_strobe  <= 1'b0;
      ser_data    <= '0;
      ser_ch      <= '0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      // Cleared first so a timeout on this same edge overrides the clear.
      if (clr_err) begin
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_any) begin
            ser_data   <= hold[gidx];
            ser_ch     <= gidx;
            ser_strobe <= 1'b1;
            rr_ptr     <= (gidx == IDX_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
            tmo_cnt    <= TMO_W'(TIMEOUT - 1);
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (ser_busy) begin
            ser_strobe <= 1'b0;
            state      <= WAIT_DONE;
          end else if (tmo_cnt == '0) begin
            ser_strobe  <= 1'b0;
            err_timeout <= 1'b1;
            gap_cnt     <= GAP_W'(GAP_CYC - 1);
            state       <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!ser_busy) begin
            gap_cnt <= GAP_W'(GAP_CYC - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          ser_strobe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef DEC_SER_SCHED_OVR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr_err) begin
          ovr_cnt[i*8 +: 8] <= ovr_evt[i] ? 8'd1 : 8'd0;
        end else if (ovr_evt[i] && (ovr_cnt[i*8 +: 8] != 8'hFF)) begin
          ovr_cnt[i*8 +: 8] <= ovr_cnt[i*8 +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dec_ser_scheduler.sv
// tb_dec_ser_scheduler
//   Directed bench for dec_ser_scheduler (default build). Expected words are
//   queued when channels are pulsed and compared as each strobe rises; a small
//   serializer model answers the strobe with a busy pulse.
module tb_dec_ser_scheduler;
  import dec_ser_pkg::*;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 22;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [1:0]        ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic                   ser_busy;
  logic                   ser_strobe;
  logic [DATA_W-1:0]      ser_data;
  logic [1:0]             ser_ch;
  logic [N_CH-1:0]        overrun;
  logic                   err_timeout;
  logic                   clr_err;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   n_rises   = 0;
  int   exp_hi_len;
  int   busy_dly;
  int   busy_len;
  logic no_busy;
  logic model_act = 1'b0;

  dec_ser_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ser_busy    (ser_busy),
    .ser_strobe  (ser_strobe),
    .ser_data    (ser_data),
    .ser_ch      (ser_ch),
    .overrun     (overrun),
    .err_timeout (err_timeout),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [DATA_W-1:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Call at a falling edge; the pulse is sampled by the next rising edge.
  task automatic drive_valid(input logic [3:0] mask, input logic [DATA_W-1:0] d0,
                             input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                             input logic [DATA_W-1:0] d3);
    ch_valid = mask;
    ch_data  = {d3, d2, d1, d0};
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic wait_strobe(input string tag, input int max_cyc);
    int n = 0;
    while (!ser_strobe && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ser_strobe, 1'b1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || ser_strobe || model_act) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_in_time", n < max_cyc, 1'b1);
    repeat (GAP_CYC + 3) @(negedge clk);
  endtask

  // Strobe monitor + serializer model, sampled on falling edges.
  task automatic monitor();
    exp_t cur;
    int   hi_len   = 0;
    int   fall_cyc = -1;
    int   cyc      = 0;
    int   model_k  = 0;
    logic prev_stb = 1'b0;
    cur.ch   = '0;
    cur.data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        model_act = 1'b0;
        ser_busy  = 1'b0;
        prev_stb  = 1'b0;
        hi_len    = 0;
        fall_cyc  = -1;
        continue;
      end
      if (ser_strobe && !prev_stb) begin
        n_rises++;
        chk("strobe_has_expected_word", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("ser_ch", ser_ch, cur.ch);
          chk("ser_data", ser_data, cur.data);
        end
        if (fall_cyc >= 0) begin
          chk("gap_low_cycles_ok", (cyc - fall_cyc - 1) >= GAP_CYC, 1'b1);
        end
        fall_cyc = -1;
        hi_len   = 1;
      end else if (ser_strobe) begin
        hi_len++;
      end
      if (!ser_strobe && prev_stb) begin
        chk("strobe_high_len", hi_len, exp_hi_len);
        chk("ser_data_stable", ser_data, cur.data);
        if (!model_act) fall_cyc = cyc - 1;
      end
      if (!model_act) begin
        if (ser_strobe && !no_busy) begin
          model_act = 1'b1;
          model_k   = 0;
        end
      end else begin
        model_k++;
        if (model_k == busy_dly) begin
          ser_busy = 1'b1;
        end else if (model_k == busy_dly + busy_len) begin
          ser_busy  = 1'b0;
          model_act = 1'b0;
          fall_cyc  = cyc;
        end
      end
      prev_stb = ser_strobe;
    end
  endtask

  initial begin
    int n;
    int rises_before;
    rst        = 1'b1;
    ch_valid   = '0;
    ch_data    = '0;
    ser_busy   = 1'b0;
    clr_err    = 1'b0;
    no_busy    = 1'b0;
    busy_dly   = 3;
    busy_len   = 22;
    exp_hi_len = 4;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_strobe", ser_strobe, 1'b0);
    chk("rst_data", ser_data, '0);
    chk("rst_ch", ser_ch, '0);
    chk("rst_overrun", overrun, '0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, busy after 4 strobe cycles, busy for 22 cycles.
    push(2'd0, 22'h2AAAAA);
    drive_valid(4'b0001, 22'h2AAAAA, '0, '0, '0);
    chk("latency_cycle1_low", ser_strobe, 1'b0);
    @(negedge clk);
    chk("latency_cycle2_high", ser_strobe, 1'b1);
    wait_idle(200);

    // Channel 1 overwritten while channel 0 is being serialized.
    push(2'd0, 22'h0ABCDE);
    drive_valid(4'b0001, 22'h0ABCDE, '0, '0, '0);
    wait_strobe("ovr_strobe_seen", 10);
    repeat (6) @(negedge clk);
    drive_valid(4'b0010, '0, 22'h000001, '0, '0);
    repeat (2) @(negedge clk);
    push(2'd1, 22'h000002);
    drive_valid(4'b0010, '0, 22'h000002, '0, '0);
    chk("overrun_set", overrun, 4'b0010);
    wait_idle(300);
    chk("overrun_sticky", overrun, 4'b0010);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("overrun_cleared", overrun, 4'b0000);

    // All four at once with rr_ptr at 2: order 2,3,0,1.
    push(2'd2, 22'h222222);
    push(2'd3, 22'h333333);
    push(2'd0, 22'h000AAA);
    push(2'd1, 22'h111111);
    drive_valid(4'b1111, 22'h000AAA, 22'h111111, 22'h222222, 22'h333333);
    wait_idle(600);
    chk("burst_no_overrun", overrun, 4'b0000);

    // New word arrives on the grant cycle of the same channel.
    push(2'd3, 22'h0C0C0C);
    drive_valid(4'b1000, '0, '0, '0, 22'h0C0C0C);
    push(2'd3, 22'h0D0D0D);
    drive_valid(4'b1000, '0, '0, '0, 22'h0D0D0D);
    wait_idle(300);
    chk("grant_cycle_no_overrun", overrun, 4'b0000);

    // Handshake timeout with clr_err held across the timeout edge.
    no_busy    = 1'b1;
    exp_hi_len = TIMEOUT;
    push(2'd0, 22'h0F0F0F);
    clr_err = 1'b1;
    drive_valid(4'b0001, 22'h0F0F0F, '0, '0, '0);
    wait_strobe("tmo_strobe_seen", 10);
    n = 0;
    while (ser_strobe && n < 40) begin
      @(negedge clk);
      n++;
    end
    clr_err = 1'b0;
    chk("tmo_strobe_dropped", ser_strobe, 1'b0);
    chk("tmo_set_beats_clear", err_timeout, 1'b1);
    wait_idle(100);
    chk("tmo_sticky", err_timeout, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("tmo_cleared", err_timeout, 1'b0);
    no_busy    = 1'b0;
    exp_hi_len = 4;

    // Reset during WAIT_DONE with two channels pending.
    busy_len = 40;
    push(2'd3, 22'h155555);
    drive_valid(4'b1000, '0, '0, '0, 22'h155555);
    wait_strobe("rst_case_strobe_seen", 10);
    repeat (8) @(negedge clk);
    drive_valid(4'b0110, '0, 22'h111111, 22'h222222, '0);
    chk("pre_rst_in_wait_done", ser_strobe, 1'b0);
    chk("pre_rst_data", ser_data, 22'h155555);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_strobe", ser_strobe, 1'b0);
    chk("async_rst_data", ser_data, '0);
    chk("async_rst_ch", ser_ch, '0);
    chk("async_rst_overrun", overrun, '0);
    chk("async_rst_err", err_timeout, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    busy_len = 22;
    rises_before = n_rises;
    repeat (40) @(negedge clk);
    chk("no_strobe_after_rst", n_rises - rises_before, 0);
    push(2'd1, 22'h3FFFFF);
    drive_valid(4'b0010, '0, 22'h3FFFFF, '0, '0);
    wait_idle(200);
    chk("post_rst_one_transfer", n_rises - rises_before, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
